// File: rtl/video_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// video_ctrl_pkg : shared state codes and control-vector layout
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package video_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_PAT   = 3'd1,
    ST_ARM   = 3'd2,
    ST_CAM   = 3'd3,
    ST_LOST  = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  typedef struct packed {
    logic       camera;
    logic       overlay;
    logic       pattern;
    logic [7:0] thresh;
  } ctrl_vec_t;

  localparam int CTRL_W = $bits(ctrl_vec_t);

endpackage

`default_nettype wire

// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------
// switch_debounce : 2-flop synchroniser plus stable-time debounce of a vector
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module switch_debounce #(
  parameter int WIDTH           = 11,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_pend
);

  localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  logic [WIDTH-1:0]   sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0]   pend_q, pend_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      sync1_q <= i_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Load happens on the edge where the counter arrives at its terminal value.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (sync2_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != c_cnt_max) begin
      cnt_d = cnt_q + c_cnt_one;
    end
    if ((sync2_q == prev_q) && (cnt_d == c_cnt_max)) begin
      pend_d = sync2_q;
    end
  end

  assign o_pend = pend_q;

endmodule

`default_nettype wire

// File: rtl/video_mode_ctrl.sv
// ---------------------------------------------------------------------------
// video_mode_ctrl : frame-synchronous source / Sobel setting sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module video_mode_ctrl
  import video_ctrl_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 1_000_000,
  parameter int         STALE_FRAMES    = 2,
  parameter logic [7:0] THRESH_RST      = 8'd64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_camera,
  input  logic       req_overlay,
  input  logic       req_pattern,
  input  logic [7:0] req_thresh,
  input  logic       start_of_frame,
  input  logic       cam_pix_valid,
  input  logic       sccb_done,
  input  logic       sccb_err,
  output logic       use_camera,
  output logic       overlay_on,
  output logic       pattern_sel,
  output logic [7:0] thresh,
  output logic       cam_lost,
  output logic       cfg_fault,
  output logic [2:0] state_o
);

  localparam int c_miss_w = $clog2(STALE_FRAMES + 1);
  localparam logic [c_miss_w-1:0] c_miss_max = c_miss_w'(STALE_FRAMES);
  localparam logic [c_miss_w-1:0] c_miss_one = c_miss_w'(1);

  logic [CTRL_W-1:0] w_raw;
  ctrl_vec_t         pend;

  assign w_raw = {req_camera, req_overlay, req_pattern, req_thresh};

  switch_debounce #(
    .WIDTH           (CTRL_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .i_raw   (w_raw),
    .o_pend  (pend)
  );

  state_t              state_q, state_d;
  logic                seen_q, seen_d;
  logic [c_miss_w-1:0] miss_cnt_q, miss_cnt_d;
  logic                use_camera_q, use_camera_d;
  logic                overlay_q, overlay_d;
  logic                pattern_q, pattern_d;
  logic [7:0]          thresh_q, thresh_d;
  logic                cam_lost_q, cam_lost_d;
  logic                cfg_fault_q, cfg_fault_d;
  logic                w_stale;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_BOOT;
      seen_q       <= 1'b0;
      miss_cnt_q   <= '0;
      use_camera_q <= 1'b0;
      overlay_q    <= 1'b0;
      pattern_q    <= 1'b0;
      thresh_q     <= THRESH_RST;
      cam_lost_q   <= 1'b0;
      cfg_fault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      seen_q       <= seen_d;
      miss_cnt_q   <= miss_cnt_d;
      use_camera_q <= use_camera_d;
      overlay_q    <= overlay_d;
      pattern_q    <= pattern_d;
      thresh_q     <= thresh_d;
      cam_lost_q   <= cam_lost_d;
      cfg_fault_q  <= cfg_fault_d;
    end
  end

  // This frame's miss would reach the limit, judged on the frame just ending.
  assign w_stale = ((32'(miss_cnt_q) + 32'd1) >= 32'(STALE_FRAMES)) && !seen_q;

  always_comb begin
    state_d    = state_q;
    seen_d     = seen_q;
    miss_cnt_d = miss_cnt_q;
    overlay_d  = overlay_q;
    pattern_d  = pattern_q;
    thresh_d   = thresh_q;

    // A pixel on the frame-start cycle belongs to the new frame.
    if (start_of_frame) begin
      seen_d = cam_pix_valid;
      if (seen_q) begin
        miss_cnt_d = '0;
      end else if (miss_cnt_q != c_miss_max) begin
        miss_cnt_d = miss_cnt_q + c_miss_one;
      end
    end else if (cam_pix_valid) begin
      seen_d = 1'b1;
    end

    case (state_q)
      ST_BOOT: begin
        if (sccb_err) begin
          state_d = ST_FAULT;
        end else if (sccb_done) begin
          state_d = ST_PAT;
        end
      end
      ST_PAT: begin
        if (start_of_frame && pend.camera) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (start_of_frame) begin
          if (!pend.camera) begin
            state_d = ST_PAT;
          end else if (seen_q) begin
            state_d = ST_CAM;
          end
        end
      end
      ST_CAM: begin
        if (start_of_frame) begin
          if (!pend.camera) begin
            state_d = ST_PAT;
          end else if (w_stale) begin
            state_d = ST_LOST;
          end
        end
      end
      ST_LOST: begin
        if (start_of_frame) begin
          if (!pend.camera) begin
            state_d = ST_PAT;
          end else if (seen_q) begin
            state_d = ST_ARM;
          end
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_BOOT;
    endcase

    // Settings track pend at frame start everywhere except before SCCB is up.
    if (start_of_frame && (state_q != ST_BOOT)) begin
      overlay_d = pend.overlay;
      pattern_d = pend.pattern;
      thresh_d  = pend.thresh;
    end

    use_camera_d = (state_d == ST_CAM);
    cam_lost_d   = (state_d == ST_LOST);
    cfg_fault_d  = (state_d == ST_FAULT);
  end

  assign use_camera  = use_camera_q;
  assign overlay_on  = overlay_q;
  assign pattern_sel = pattern_q;
  assign thresh      = thresh_q;
  assign cam_lost    = cam_lost_q;
  assign cfg_fault   = cfg_fault_q;
  assign state_o     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_video_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_video_mode_ctrl : directed scoreboard bench for video_mode_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_video_mode_ctrl;
  import video_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_camera, req_overlay, req_pattern;
  logic [7:0] req_thresh;
  logic       start_of_frame, cam_pix_valid, sccb_done, sccb_err;
  logic       use_camera, overlay_on, pattern_sel, cam_lost, cfg_fault;
  logic [7:0] thresh;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  video_mode_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .STALE_FRAMES    (2),
    .THRESH_RST      (8'd64)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_camera     (req_camera),
    .req_overlay    (req_overlay),
    .req_pattern    (req_pattern),
    .req_thresh     (req_thresh),
    .start_of_frame (start_of_frame),
    .cam_pix_valid  (cam_pix_valid),
    .sccb_done      (sccb_done),
    .sccb_err       (sccb_err),
    .use_camera     (use_camera),
    .overlay_on     (overlay_on),
    .pattern_sel    (pattern_sel),
    .thresh         (thresh),
    .cam_lost       (cam_lost),
    .cfg_fault      (cfg_fault),
    .state_o        (state_o)
  );

  // {state, use_camera, overlay, pattern, thresh, lost, fault}
  logic [15:0] obs;
  assign obs = {state_o, use_camera, overlay_on, pattern_sel, thresh, cam_lost, cfg_fault};

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [15:0] pk(input state_t st, input logic uc, input logic ov,
                                     input logic pat, input logic [7:0] th,
                                     input logic lost, input logic flt);
    return {st, uc, ov, pat, th, lost, flt};
  endfunction

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sof(input logic pix);
    start_of_frame = 1'b1;
    cam_pix_valid  = pix;
    tick(1);
    start_of_frame = 1'b0;
    cam_pix_valid  = 1'b0;
  endtask

  task automatic frame(input logic pix);
    cam_pix_valid = pix;
    tick(5);
    cam_pix_valid = 1'b0;
    sof(1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    req_camera = 1'b0; req_overlay = 1'b0; req_pattern = 1'b0; req_thresh = 8'h00;
    start_of_frame = 1'b0; cam_pix_valid = 1'b0; sccb_done = 1'b0; sccb_err = 1'b0;

    push("reset", pk(ST_BOOT, 0, 0, 0, 8'd64, 0, 0));
    tick(3);
    drain();

    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push("boot_wait", pk(ST_BOOT, 0, 0, 0, 8'd64, 0, 0));
      frame(1'b0);
      drain();
    end

    push("boot_done", pk(ST_PAT, 0, 0, 0, 8'd64, 0, 0));
    sccb_done = 1'b1;
    tick(1);
    drain();

    push("thresh_hold", pk(ST_PAT, 0, 0, 0, 8'd64, 0, 0));
    req_thresh = 8'hA0;
    tick(8);
    drain();
    push("thresh_apply", pk(ST_PAT, 0, 0, 0, 8'hA0, 0, 0));
    sof(1'b0);
    drain();

    // pend takes 8'h55 on the very edge that samples the frame start
    push("thresh_sof_race", pk(ST_PAT, 0, 0, 0, 8'hA0, 0, 0));
    req_thresh = 8'h55;
    tick(5);
    sof(1'b0);
    drain();
    push("thresh_next", pk(ST_PAT, 0, 0, 0, 8'h55, 0, 0));
    tick(2);
    sof(1'b0);
    drain();

    for (int i = 0; i < 10; i++) begin
      req_overlay = ~req_overlay;
      tick(2);
    end
    req_overlay = 1'b1;
    push("bounce_early", pk(ST_PAT, 0, 0, 0, 8'h55, 0, 0));
    tick(4);
    sof(1'b0);
    drain();
    push("bounce_settled", pk(ST_PAT, 0, 1, 0, 8'h55, 0, 0));
    tick(3);
    sof(1'b0);
    drain();

    req_camera = 1'b1;
    tick(6);
    push("arm", pk(ST_ARM, 0, 1, 0, 8'h55, 0, 0));
    sof(1'b0);
    drain();
    push("cam", pk(ST_CAM, 1, 1, 0, 8'h55, 0, 0));
    frame(1'b1);
    drain();
    push("cam_hold", pk(ST_CAM, 1, 1, 0, 8'h55, 0, 0));
    frame(1'b1);
    drain();

    push("miss1", pk(ST_CAM, 1, 1, 0, 8'h55, 0, 0));
    frame(1'b0);
    drain();
    push("lost", pk(ST_LOST, 0, 1, 0, 8'h55, 1, 0));
    frame(1'b0);
    drain();
    push("rearm", pk(ST_ARM, 0, 1, 0, 8'h55, 0, 0));
    frame(1'b1);
    drain();
    push("recam", pk(ST_CAM, 1, 1, 0, 8'h55, 0, 0));
    frame(1'b1);
    drain();

    // A pixel only on the frame-start cycle must count for the following frame
    push("pix_on_sof_a", pk(ST_CAM, 1, 1, 0, 8'h55, 0, 0));
    tick(5);
    sof(1'b1);
    drain();
    push("pix_on_sof_b", pk(ST_CAM, 1, 1, 0, 8'h55, 0, 0));
    tick(5);
    sof(1'b0);
    drain();

    req_camera = 1'b0;
    tick(6);
    push("drop", pk(ST_PAT, 0, 1, 0, 8'h55, 0, 0));
    sof(1'b0);
    drain();

    sccb_done = 1'b0;
    tick(2);
    reset_n = 1'b0;
    #2;
    push("async_reset", pk(ST_BOOT, 0, 0, 0, 8'd64, 0, 0));
    drain();
    tick(2);

    reset_n    = 1'b1;
    sccb_err   = 1'b1;
    sccb_done  = 1'b1;
    req_camera = 1'b1;
    push("fault", pk(ST_FAULT, 0, 0, 0, 8'd64, 0, 1));
    tick(1);
    drain();
    tick(8);
    push("fault_follow", pk(ST_FAULT, 0, 1, 0, 8'h55, 0, 1));
    sof(1'b0);
    drain();
    push("fault_cam", pk(ST_FAULT, 0, 1, 0, 8'h55, 0, 1));
    frame(1'b1);
    drain();
    push("fault_cam2", pk(ST_FAULT, 0, 1, 0, 8'h55, 0, 1));
    frame(1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
